// File: rtl/seed_sequencer.sv
// Seed campaign sequencer: walks seeds from memory through the network datapath,
// one run per seed, and presents each run's final state over a valid/ready result port.
module seed_sequencer #(
    parameter int unsigned          STATE_W    = 64,
    parameter int unsigned          LOG_RULES  = 6,
    parameter int unsigned          NUM_SEEDS  = 200,
    parameter logic [9:0]           ITER_LIMIT = 10'd100,
    parameter logic [LOG_RULES-1:0] INHIBITOR  = '0,
    parameter bit                   EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic [7:0]           seed_addr,
    input  logic [STATE_W-1:0]   seed_data,
    output logic                 dp_rst,
    output logic                 dp_ld_inhibitor,
    output logic                 dp_start,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic [STATE_W-1:0]   dp_initial_state,
    input  logic [STATE_W-1:0]   dp_network_state,
    input  logic                 dp_steady_state,
    input  logic [9:0]           dp_iteration_number,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [7:0]           res_seed,
    output logic [STATE_W-1:0]   res_state,
    output logic [9:0]           res_iters,
    output logic                 res_steady,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StLoad,
        StRelease,
        StInhib,
        StGap,
        StStart,
        StRun,
        StEmit,
        StNext
    } state_e;

    localparam logic [7:0] LastIdx = 8'(NUM_SEEDS - 1);

    state_e               state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic                 dp_rst_q, dp_rst_d;
    logic                 done_q, done_d;
    logic                 run_exit;
    logic [STATE_W-1:0]   init_q;
    logic [7:0]           res_seed_q;
    logic [STATE_W-1:0]   res_state_q;
    logic [9:0]           res_iters_q;
    logic                 res_steady_q;

    assign run_exit = (dp_iteration_number >= ITER_LIMIT) || (EARLY_EXIT && dp_steady_state);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dp_rst_d = dp_rst_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                idx_d = 8'd0;
                if (go) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // dp_rst is registered, so it is cleared one cycle ahead to be low in LOAD
                dp_rst_d = 1'b0;
                state_d  = StLoad;
            end
            StLoad: begin
                dp_rst_d = 1'b1;
                state_d  = StRelease;
            end
            StRelease: state_d = StInhib;
            StInhib:   state_d = StGap;
            StGap:     state_d = StStart;
            StStart:   state_d = StRun;
            StRun: begin
                if (run_exit) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (res_ready) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StFetch;
                    idx_d   = idx_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= 8'd0;
            dp_rst_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dp_rst_q <= dp_rst_d;
            done_q   <= done_d;
        end
    end

    // Seed word arrives the cycle after its address, i.e. during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= '0;
        end else if (state_q == StLoad) begin
            init_q <= seed_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_seed_q   <= 8'd0;
            res_state_q  <= '0;
            res_iters_q  <= 10'd0;
            res_steady_q <= 1'b0;
        end else if ((state_q == StRun) && run_exit) begin
            res_seed_q   <= idx_q;
            res_state_q  <= dp_network_state;
            res_iters_q  <= dp_iteration_number;
            res_steady_q <= dp_steady_state;
        end
    end

    assign seed_addr        = idx_q;
    assign dp_rst           = dp_rst_q;
    assign dp_ld_inhibitor  = (state_q == StInhib);
    assign dp_start         = (state_q == StStart);
    assign dp_sel_inhibitor = ~INHIBITOR;
    assign dp_initial_state = init_q;
    assign res_valid        = (state_q == StEmit);
    assign res_seed         = res_seed_q;
    assign res_state        = res_state_q;
    assign res_iters        = res_iters_q;
    assign res_steady       = res_steady_q;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;

endmodule

// File: tb/tb_seed_sequencer.sv
// Directed bench for seed_sequencer: two instances (EARLY_EXIT 0 and 1), each with a
// synchronous seed memory and a counting datapath model.
module tb_seed_sequencer;

    logic        clk;
    logic        rst;
    logic        go0;
    logic        go1;
    logic        res_ready;
    logic [9:0]  steady_at;
    logic [63:0] mem [4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        go_w;
        logic [7:0]  seed_addr;
        logic [63:0] seed_data;
        logic        dp_rst;
        logic        ld;
        logic        start;
        logic [5:0]  sel;
        logic [63:0] init_state;
        logic [63:0] net_state;
        logic        steady;
        logic [9:0]  iter;
        logic        running;
        logic        res_valid;
        logic [7:0]  res_seed;
        logic [63:0] res_state;
        logic [9:0]  res_iters;
        logic        res_steady;
        logic        busy;
        logic        done;

        assign go_w = (g == 0) ? go0 : go1;

        seed_sequencer #(
            .STATE_W    (64),
            .LOG_RULES  (6),
            .NUM_SEEDS  ((g == 0) ? 3 : 2),
            .ITER_LIMIT (10'd5),
            .INHIBITOR  (6'h05),
            .EARLY_EXIT (g == 1)
        ) u_dut (
            .clk                 (clk),
            .rst                 (rst),
            .go                  (go_w),
            .seed_addr           (seed_addr),
            .seed_data           (seed_data),
            .dp_rst              (dp_rst),
            .dp_ld_inhibitor     (ld),
            .dp_start            (start),
            .dp_sel_inhibitor    (sel),
            .dp_initial_state    (init_state),
            .dp_network_state    (net_state),
            .dp_steady_state     (steady),
            .dp_iteration_number (iter),
            .res_valid           (res_valid),
            .res_ready           (res_ready),
            .res_seed            (res_seed),
            .res_state           (res_state),
            .res_iters           (res_iters),
            .res_steady          (res_steady),
            .busy                (busy),
            .done                (done)
        );

        // Datapath model: iteration 1 in the first cycle after start, +1 per cycle.
        always @(posedge clk) begin
            seed_data <= mem[seed_addr[1:0]];
            if (!dp_rst) begin
                running <= 1'b0;
                iter    <= 10'd0;
            end else if (start) begin
                running <= 1'b1;
                iter    <= 10'd1;
            end else if (running) begin
                iter <= iter + 10'd1;
            end
        end

        assign steady    = running && (iter >= steady_at);
        assign net_state = init_state ^ {54'd0, iter};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, g_dut[0].busy, 1'b0);
        chk({tag, "_valid"}, g_dut[0].res_valid, 1'b0);
        chk({tag, "_dp_rst"}, g_dut[0].dp_rst, 1'b0);
        chk({tag, "_addr"}, g_dut[0].seed_addr, 8'd0);
        chk({tag, "_ld"}, g_dut[0].ld, 1'b0);
        chk({tag, "_start"}, g_dut[0].start, 1'b0);
        chk({tag, "_done"}, g_dut[0].done, 1'b0);
        chk({tag, "_res_seed"}, g_dut[0].res_seed, 8'd0);
        chk({tag, "_res_iters"}, g_dut[0].res_iters, 10'd0);
        chk({tag, "_res_state"}, g_dut[0].res_state, 64'd0);
        chk({tag, "_res_steady"}, g_dut[0].res_steady, 1'b0);
        chk({tag, "_init"}, g_dut[0].init_state, 64'd0);
        chk({tag, "_sel"}, g_dut[0].sel, 6'h3A);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        rst       = 1'b1;
        go0       = 1'b0;
        go1       = 1'b0;
        res_ready = 1'b1;
        steady_at = 10'd1023;
        mem[0]    = 64'hA5A5_A5A5_A5A5_A5A5;
        mem[1]    = 64'h3C3C_3C3C_3C3C_3C3C;
        mem[2]    = 64'h0123_4567_89AB_CDEF;
        mem[3]    = 64'd0;

        repeat (2) tick();
        chk_reset_outputs("rst");
        chk("rst_sel_ee", g_dut[1].sel, 6'h3A);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_busy", g_dut[0].busy, 1'b0);

        // Full campaign, ready tied high; go pulsed again mid-run of seed 1.
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("s%0d_fetch_addr", s), g_dut[0].seed_addr, 8'(s));
            chk($sformatf("s%0d_fetch_busy", s), g_dut[0].busy, 1'b1);
            if (s > 0) chk($sformatf("s%0d_fetch_dp_rst", s), g_dut[0].dp_rst, 1'b1);
            tick();
            chk($sformatf("s%0d_load_dp_rst", s), g_dut[0].dp_rst, 1'b0);
            tick();
            chk($sformatf("s%0d_release_dp_rst", s), g_dut[0].dp_rst, 1'b1);
            chk($sformatf("s%0d_init", s), g_dut[0].init_state, mem[s]);
            tick();
            chk($sformatf("s%0d_inhib_ld", s), g_dut[0].ld, 1'b1);
            chk($sformatf("s%0d_inhib_start", s), g_dut[0].start, 1'b0);
            tick();
            chk($sformatf("s%0d_gap_ld", s), g_dut[0].ld, 1'b0);
            chk($sformatf("s%0d_gap_start", s), g_dut[0].start, 1'b0);
            tick();
            chk($sformatf("s%0d_start_start", s), g_dut[0].start, 1'b1);
            chk($sformatf("s%0d_start_ld", s), g_dut[0].ld, 1'b0);
            for (int k = 1; k <= 5; k++) begin
                tick();
                if (s == 1 && k == 2) go0 = 1'b1;
                if (s == 1 && k == 3) go0 = 1'b0;
                chk($sformatf("s%0d_run%0d_valid", s, k), g_dut[0].res_valid, 1'b0);
                chk($sformatf("s%0d_run%0d_init", s, k), g_dut[0].init_state, mem[s]);
            end
            tick();
            chk($sformatf("s%0d_emit_valid", s), g_dut[0].res_valid, 1'b1);
            chk($sformatf("s%0d_emit_seed", s), g_dut[0].res_seed, 8'(s));
            chk($sformatf("s%0d_emit_iters", s), g_dut[0].res_iters, 10'd5);
            chk($sformatf("s%0d_emit_state", s), g_dut[0].res_state, mem[s] ^ 64'd5);
            chk($sformatf("s%0d_emit_steady", s), g_dut[0].res_steady, 1'b0);
            tick();
            chk($sformatf("s%0d_next_valid", s), g_dut[0].res_valid, 1'b0);
            chk($sformatf("s%0d_next_done", s), g_dut[0].done, 1'b0);
            chk($sformatf("s%0d_next_dp_rst", s), g_dut[0].dp_rst, 1'b1);
            tick();
        end
        chk("end_done", g_dut[0].done, 1'b1);
        chk("end_busy", g_dut[0].busy, 1'b0);
        chk("end_addr", g_dut[0].seed_addr, 8'd0);
        tick();
        chk("end_done_pulse", g_dut[0].done, 1'b0);
        chk("end_busy_after", g_dut[0].busy, 1'b0);

        // Back-pressure: ready low for 10 EMIT cycles.
        res_ready = 1'b0;
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        n = 0;
        while (!g_dut[0].res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_emit_reached", g_dut[0].res_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp%0d_valid", k), g_dut[0].res_valid, 1'b1);
            chk($sformatf("bp%0d_seed", k), g_dut[0].res_seed, 8'd0);
            chk($sformatf("bp%0d_iters", k), g_dut[0].res_iters, 10'd5);
            chk($sformatf("bp%0d_state", k), g_dut[0].res_state, mem[0] ^ 64'd5);
            if (k < 9) tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_next_valid", g_dut[0].res_valid, 1'b0);
        tick();
        chk("bp_fetch_addr", g_dut[0].seed_addr, 8'd1);

        // Asynchronous reset during RUN of seed 1.
        n = 0;
        while (!g_dut[0].start && n < 20) begin
            tick();
            n++;
        end
        chk("abort_start_seen", g_dut[0].start, 1'b1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        tick();
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            tick();
            if (g_dut[0].res_valid || g_dut[0].busy) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        chk("restart_addr", g_dut[0].seed_addr, 8'd0);
        chk("restart_busy", g_dut[0].busy, 1'b1);
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Steady state from iteration 2: early exit vs. full run.
        steady_at = 10'd2;
        go0 = 1'b1;
        go1 = 1'b1;
        tick();
        go0 = 1'b0;
        go1 = 1'b0;
        repeat (8) tick();
        chk("ee_valid", g_dut[1].res_valid, 1'b1);
        chk("ee_iters", g_dut[1].res_iters, 10'd2);
        chk("ee_steady", g_dut[1].res_steady, 1'b1);
        chk("ee_seed", g_dut[1].res_seed, 8'd0);
        chk("ee_state", g_dut[1].res_state, mem[0] ^ 64'd2);
        chk("noee_still_run", g_dut[0].res_valid, 1'b0);
        repeat (3) tick();
        chk("noee_valid", g_dut[0].res_valid, 1'b1);
        chk("noee_iters", g_dut[0].res_iters, 10'd5);
        chk("noee_steady", g_dut[0].res_steady, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
